// File: rtl/usb_rst_pkg.sv
// Shared types and constants for the USB host controller reset sequencer.
package usb_rst_pkg;

    // Encoding is visible to software through the status register.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StHold   = 2'd2,
        StSettle = 2'd3
    } state_e;

    // Avalon-MM word addresses
    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    // Default timing at 50 MHz: 100 us minimum assert, 1 ms settle
    localparam int unsigned DefMinAssertCyc = 5000;
    localparam int unsigned DefSettleCyc    = 50000;
    localparam int unsigned DefCntW         = 20;

endpackage

// File: rtl/usb_rst_timer.sv
// Loadable down-counter with a zero flag; stops at zero.
module usb_rst_timer #(
    parameter int unsigned         CNT_W   = 20,
    parameter logic [CNT_W-1:0]    RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/usb_rst_seq.sv
// USB host controller reset sequencer: stretches a reset request into a
// minimum-width active-low pulse, then waits for the controller to settle.
module usb_rst_seq
    import usb_rst_pkg::*;
#(
    parameter int unsigned MIN_ASSERT_CYC = DefMinAssertCyc,
    parameter int unsigned SETTLE_CYC     = DefSettleCyc,
    parameter int unsigned CNT_W          = DefCntW
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        usb_rst_n,
    output logic        ready
);

    localparam logic [CNT_W-1:0] AssertLoad = CNT_W'(MIN_ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic             req_q;
    logic             sw_trig_q;
    logic             usb_rst_n_q;
    logic             ready_q;
    logic [15:0]      pulse_cnt_q, pulse_cnt_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;
    logic             wr_en;
    logic             req_event;
    logic             seq_done;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    // A pin edge and a software trigger in the same cycle merge into one event.
    assign req_event    = (req && !req_q) || sw_trig_q;
    assign unused_wdata = ^writedata[31:1];

    usb_rst_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (AssertLoad)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state, timer control and completion detect.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = AssertLoad;
        tmr_dec      = 1'b0;
        seq_done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_event) begin
                    state_d  = StAssert;
                    tmr_load = 1'b1;
                end
            end
            StAssert: begin
                if (tmr_zero) begin
                    if (req) begin
                        state_d = StHold;
                    end else begin
                        state_d      = StSettle;
                        tmr_load     = 1'b1;
                        tmr_load_val = SettleLoad;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StHold: begin
                if (!req) begin
                    state_d      = StSettle;
                    tmr_load     = 1'b1;
                    tmr_load_val = SettleLoad;
                end
            end
            StSettle: begin
                if (req_event) begin
                    state_d  = StAssert;
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = StIdle;
                    seq_done = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completed-pulse counter; a software clear beats a same-cycle increment.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (seq_done) begin
            pulse_cnt_d = pulse_cnt_q + 16'd1;
        end
        if (wr_en && (address == AddrCount)) begin
            pulse_cnt_d = '0;
        end
    end

    // State and outputs; outputs decode the next state so they change with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StAssert;
            req_q       <= 1'b0;
            sw_trig_q   <= 1'b0;
            usb_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req;
            sw_trig_q   <= wr_en && (address == AddrCtrl) && writedata[0];
            usb_rst_n_q <= !((state_d == StAssert) || (state_d == StHold));
            ready_q     <= (state_d == StIdle);
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        unique case (address)
            AddrStatus: readdata = {28'd0, state_q, (state_q != StIdle), ready_q};
            AddrCount:  readdata = {16'd0, pulse_cnt_q};
            default:    readdata = '0;
        endcase
    end

    assign usb_rst_n = usb_rst_n_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_usb_rst_seq.sv
// Self-checking bench for usb_rst_seq with short timing parameters.
module tb_usb_rst_seq;

    localparam int unsigned M = 4;
    localparam int unsigned S = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        usb_rst_n;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the observable behaviour
    logic        m_lo;
    int          m_lo_el;
    int          m_set_el;
    logic        m_rdy;
    logic [15:0] m_cnt;
    logic        m_req_prev;
    logic        m_sw;

    always #5 clk = ~clk;

    usb_rst_seq #(
        .MIN_ASSERT_CYC (M),
        .SETTLE_CYC     (S),
        .CNT_W          (20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .usb_rst_n  (usb_rst_n),
        .ready      (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    // Count low samples from now, then settling samples, each bounded.
    task automatic measure(output int lo, output int st);
        lo = 0;
        while (usb_rst_n === 1'b0 && lo < 100) begin
            lo++;
            tick();
        end
        st = 0;
        while (usb_rst_n === 1'b1 && ready === 1'b0 && st < 100) begin
            st++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lo, st;
        reset_n = 1'b0; req = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;
        repeat (3) tick();
        n_checks++;
        if (usb_rst_n !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rst_n=%b ready=%b, expected 0 0", usb_rst_n, ready);
        end
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h6) begin
            n_fail++; $display("FAIL reset_status: got %h expected %h", rd, 32'h6);
        end
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_count: got %h expected 0", rd);
        end
        reset_n = 1'b1;
        measure(lo, st);
        n_checks++;
        if (lo != M || st != S || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got low=%0d settle=%0d ready=%b, expected %0d %0d 1",
                     lo, st, ready, M, S);
        end
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL idle_status: got %h expected 1", rd);
        end
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL reset_seq_count: got %h expected 1", rd);
        end
    endtask

    task automatic test_req_pulse();
        logic [31:0] rd;
        int lo, st;
        req = 1'b1; tick(); req = 1'b0;
        measure(lo, st);
        n_checks++;
        if (lo != M || st != S) begin
            n_fail++;
            $display("FAIL req_pulse: got low=%0d settle=%0d, expected %0d %0d", lo, st, M, S);
        end
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL req_pulse_count: got %h expected 2", rd);
        end
    endtask

    task automatic test_req_hold();
        logic [31:0] rd;
        int lo, st;
        req = 1'b1; tick();
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h6) begin
            n_fail++; $display("FAIL hold_assert_status: got %h expected 6", rd);
        end
        repeat (9) tick();
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'hA || usb_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_status: got %h rst_n=%b, expected a 0", rd, usb_rst_n);
        end
        req = 1'b0; tick();
        n_checks++;
        if (usb_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL hold_release: got rst_n=%b expected 1", usb_rst_n);
        end
        measure(lo, st);
        n_checks++;
        if (lo != 0 || st != S) begin
            n_fail++; $display("FAIL hold_settle: got low=%0d settle=%0d, expected 0 %0d", lo, st, S);
        end
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++; $display("FAIL hold_count: got %h expected 3", rd);
        end
    endtask

    task automatic test_sw_in_settle();
        logic [31:0] rd;
        int lo, st;
        req = 1'b1; tick(); req = 1'b0;
        repeat (4) tick();
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'hE || usb_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL settle_status: got %h rst_n=%b, expected e 1", rd, usb_rst_n);
        end
        repeat (2) tick();
        bus_write(2'd0, 32'h1);
        tick();
        measure(lo, st);
        n_checks++;
        if (lo != M || st != S) begin
            n_fail++;
            $display("FAIL sw_restart: got low=%0d settle=%0d, expected %0d %0d", lo, st, M, S);
        end
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h4) begin
            n_fail++; $display("FAIL sw_restart_count: got %h expected 4", rd);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] rd;
        int lo, st, extra;
        bus_write(2'd0, 32'h1);
        req = 1'b1; tick(); req = 1'b0;
        measure(lo, st);
        n_checks++;
        if (lo != M || st != S) begin
            n_fail++;
            $display("FAIL same_cycle: got low=%0d settle=%0d, expected %0d %0d", lo, st, M, S);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (usb_rst_n === 1'b0) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL same_cycle_extra: got %0d low cycles expected 0", extra);
        end
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h5) begin
            n_fail++; $display("FAIL same_cycle_count: got %h expected 5", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int lo, st;
        force dut.pulse_cnt_q = 16'hFFFF;
        tick();
        release dut.pulse_cnt_q;
        tick();
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'hFFFF) begin
            n_fail++; $display("FAIL wrap_preload: got %h expected ffff", rd);
        end
        req = 1'b1; tick(); req = 1'b0;
        measure(lo, st);
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL wrap_count: got %h expected 0", rd);
        end
        req = 1'b1; tick(); req = 1'b0;
        repeat (3 + S) tick();
        n_checks++;
        if (usb_rst_n !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL last_settle: got rst_n=%b ready=%b expected 1 0", usb_rst_n, ready);
        end
        bus_write(2'd2, $urandom());
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_wins: got %h ready=%b expected 0 1", rd, ready);
        end
    endtask

    task automatic model_edge();
        logic wr, ev, done;
        if (!reset_n) begin
            m_lo = 1'b1; m_lo_el = 1; m_set_el = 0; m_rdy = 1'b0;
            m_cnt = '0; m_req_prev = 1'b0; m_sw = 1'b0;
        end else begin
            wr   = chipselect && !write_n;
            ev   = (req && !m_req_prev) || m_sw;
            done = 1'b0;
            if (m_lo) begin
                if (m_lo_el >= int'(M) && !req) begin
                    m_lo = 1'b0; m_set_el = 1;
                end else begin
                    m_lo_el++;
                end
            end else if (!m_rdy) begin
                if (ev) begin
                    m_lo = 1'b1; m_lo_el = 1;
                end else if (m_set_el >= int'(S)) begin
                    m_rdy = 1'b1; done = 1'b1;
                end else begin
                    m_set_el++;
                end
            end else if (ev) begin
                m_lo = 1'b1; m_lo_el = 1; m_rdy = 1'b0;
            end
            if (wr && address == 2'd2) m_cnt = '0;
            else if (done) m_cnt = m_cnt + 16'd1;
            m_sw       = wr && (address == 2'd0) && writedata[0];
            m_req_prev = req;
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        logic [1:0]  code;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        @(posedge clk); model_edge(); #1;
        for (int c = 0; c < 3000; c++) begin
            reset_n    = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 11) == 0) req = ~req;
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = 1'($urandom_range(0, 1));
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom();
            #1;
            code = m_lo ? ((m_lo_el > int'(M)) ? 2'd2 : 2'd1) : (m_rdy ? 2'd0 : 2'd3);
            case (address)
                2'd1:    exp_rd = {28'd0, code, !m_rdy, m_rdy};
                2'd2:    exp_rd = {16'd0, m_cnt};
                default: exp_rd = '0;
            endcase
            n_checks++;
            if (readdata !== exp_rd) begin
                n_fail++;
                $display("FAIL rand_read c=%0d addr=%0d: got %h expected %h", c, address,
                         readdata, exp_rd);
            end
            @(posedge clk);
            model_edge();
            #1;
            n_checks++;
            if (usb_rst_n !== !m_lo || ready !== m_rdy) begin
                n_fail++;
                $display("FAIL rand_out c=%0d: got rst_n=%b ready=%b expected %b %b", c,
                         usb_rst_n, ready, !m_lo, m_rdy);
            end
        end
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_req_pulse();
        test_req_hold();
        test_sw_in_settle();
        test_same_cycle();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_rst_seq.md
USB_RST_SEQ -- requirements
Module: usb_rst_seq

Interface
REQ-001 Parameter MIN_ASSERT_CYC, default 5000, minimum usb_rst_n low time in clk cycles (100 us at 50 MHz); legal range 1 to 2^CNT_W-1.
REQ-002 Parameter SETTLE_CYC, default 50000, post-release wait before ready in clk cycles (1 ms); legal range 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 20, width of the timing counter.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 req  in  1  reset request level, driven by the USB reset PIO out_port.
REQ-007 address  in  2  Avalon-MM slave word address.
REQ-008 chipselect  in  1  Avalon-MM slave select.
REQ-009 write_n  in  1  Avalon-MM write strobe, active-low.
REQ-010 writedata  in  32  Avalon-MM write data.
REQ-011 readdata  out  32  Avalon-MM read data, zero wait states, combinational from address.
REQ-012 usb_rst_n  out  1  registered active-low reset to the USB host controller.
REQ-013 ready  out  1  registered; high when the USB controller is out of reset and settled.

Function
REQ-014 Request event: rising edge of req, using a registered copy of req, OR a write of 1 to address 0 bit 0 (sw_trig); both events in one cycle count as one event.
REQ-015 FSM states are IDLE, ASSERT, HOLD and SETTLE.
REQ-016 IDLE: usb_rst_n=1, ready=1; on a request event go to ASSERT and load the counter with MIN_ASSERT_CYC-1.
REQ-017 ASSERT: usb_rst_n=0, ready=0; decrement the counter each cycle; request events are ignored.
REQ-018 ASSERT exit at counter==0: go to HOLD if req=1, else go to SETTLE and load SETTLE_CYC-1.
REQ-019 HOLD: usb_rst_n=0, ready=0; when req=0, go to SETTLE and load SETTLE_CYC-1.
REQ-020 SETTLE: usb_rst_n=1, ready=0; decrement the counter; at 0 go to IDLE and increment pulse_cnt.
REQ-021 A request event in SETTLE restarts ASSERT (reload MIN_ASSERT_CYC-1), and pulse_cnt is not incremented.
REQ-022 usb_rst_n and ready are registered FSM decodes: the first low cycle of usb_rst_n is the cycle after the request event is sampled.
REQ-023 Total low time is exactly MIN_ASSERT_CYC cycles when req falls before ASSERT completes.
REQ-024 Address 0 write: bit0=1 sets sw_trig for one cycle (self-clearing); reads return 0.
REQ-025 Address 1 read: {28'b0, state[1:0], busy, ready}; busy = state!=IDLE; state encoding IDLE=0, ASSERT=1, HOLD=2, SETTLE=3.
REQ-026 Address 2 read: {16'b0, pulse_cnt[15:0]}; pulse_cnt wraps 0xFFFF->0; a write of any value to address 2 clears it, and the clear wins over a same-cycle increment.
REQ-027 Address 3 reads return 0; writes to addresses 1 and 3 are ignored.
REQ-028 Writes take effect only when chipselect=1 and write_n=0.

Reset
REQ-029 While reset_n=0 at a clk edge: state=ASSERT, counter=MIN_ASSERT_CYC-1, usb_rst_n=0, ready=0, pulse_cnt=0, sw_trig=0, req register=0.
REQ-030 Consequence: every system reset produces a full minimum-width USB reset pulse followed by settling; a reset mid-sequence restarts from ASSERT.

Structure
REQ-031 Shared package usb_rst_pkg holds the state enum, the register address constants (CTRL=0, STATUS=1, COUNT=2), and the default timing constants.
REQ-032 One sub-module, usb_rst_timer: a loadable down-counter with a zero flag, instantiated once.
REQ-033 No other sub-modules.

Verification (MIN_ASSERT_CYC=4, SETTLE_CYC=8)
REQ-034 Reset release: usb_rst_n low for 4 cycles after reset, then high; ready rises 8 cycles later; status reads 0x1.
REQ-035 req pulse of 1 cycle in IDLE: usb_rst_n low exactly 4 cycles, ready returns after 8 more, pulse_cnt reads 2 (1 from reset sequence + 1).
REQ-036 req held high for 10 cycles: state 1 then 2; usb_rst_n stays low until the cycle after req falls; SETTLE is then 8 cycles.
REQ-037 Software write 0x1 to address 0 during SETTLE: ASSERT restarts, usb_rst_n low 4 cycles, and pulse_cnt is incremented only once.
REQ-038 req rising edge and software trigger in the same cycle: one pulse only; pulse_cnt +1.
REQ-039 pulse_cnt preloaded to 0xFFFF by forcing: next completion reads 0x0000; a write to address 2 in the completion cycle leaves 0.
